checkbits_seq_monitor: RTL
==========================

# checkbits_seq_monitor

Parametrised checkpoint-sequence monitor for the Caravel user-project GPIO check bus. It watches a `WIDTH`-bit marker bus (normally `mprj_io[31:16]`) and debounces each value over `STABLE_CYC` cycles. It then matches the accepted values in order against `NUM_CHK` expected markers and enforces a cycle timeout. It reports pass, fail and timeout as registered flags, and emits a strobe on every accepted marker change. It sits beside the management SoC in bench and emulation builds, and replaces per-test hand-written wait chains.

## Interface
- `WIDTH`, 16, check-bus width.
- `NUM_CHK`, 2, number of expected checkpoints (≥1).
- `STABLE_CYC`, 2, consecutive equal samples required to accept a value (≥1).
- `TIMEOUT_CYC`, 250000, cycles from start until timeout (≥2).
- `clock`  in  1  single clock domain.
- `resetb`  in  1  asynchronous active-low reset.
- `start`  in  1  arm pulse.
- `checkbits`  in  WIDTH  monitored marker bus; may be asynchronous to `clock`.
- `exp_vals`  in  NUM_CHK*WIDTH  expected markers; checkpoint i is `exp_vals[i*WIDTH +: WIDTH]`. Held static while `busy`.
- `busy`  out  1  high in ARMED.
- `pass`  out  1  sticky; all checkpoints matched.
- `fail`  out  1  sticky; timeout or ordering error.
- `timeout`  out  1  sticky; set together with `fail` when the cause is the timer.
- `err_ooo`  out  1  sticky out-of-order error (see Configuration).
- `chk_idx`  out  $clog2(NUM_CHK+1)  next checkpoint to match; equals NUM_CHK after pass.
- `change_stb`  out  1  one-cycle pulse on each accepted new value.
- `change_val`  out  WIDTH  last accepted value.
- `cycle_cnt`  out  $clog2(TIMEOUT_CYC+1)  cycles elapsed since start; freezes at pass or fail.

## Operation
- Reset: all outputs 0, state IDLE, `samp`=0, `run`=0, `acc_vld`=0.
- Debounce runs in every state.
  - `samp`<=`checkbits` each edge.
  - `run`<=0 if `checkbits`!=`samp`, else saturating `run`+1, saturating at STABLE_CYC.
  - A value is accepted on the edge where `run` becomes STABLE_CYC and (`!acc_vld` or value != `change_val`).
  - On acceptance: `change_val`<=value, `acc_vld`<=1, `change_stb`=1 for one cycle.
- FSM states: IDLE, ARMED, PASS, FAIL.
  - IDLE/PASS/FAIL + `start`: go to ARMED. Clear `pass`/`fail`/`timeout`/`err_ooo`/`chk_idx`/`cycle_cnt`. Clear `run` and `acc_vld`, so a value already on the bus is re-qualified and can match checkpoint 0.
  - ARMED + `start`: ignored.
  - ARMED, acceptance of `exp[chk_idx]`: `chk_idx`+1. If that was the last checkpoint, set `pass` and go to PASS.
  - ARMED, acceptance of any other value: ignored (default build).
  - ARMED, `cycle_cnt`==TIMEOUT_CYC-1 and no pass on this edge: set `fail` and `timeout`, go to FAIL.
- `cycle_cnt` increments each ARMED cycle and never wraps.

## Timing
- Let V first be sampled into `samp` at edge k and then held.
  - V is accepted at edge k+STABLE_CYC.
  - `change_stb`, `change_val` and the `chk_idx`/`pass` update are visible in the cycle after that edge.
- A glitch shorter than STABLE_CYC+1 edges produces no strobe.
- Returning to the already-accepted value produces no strobe.
- Simultaneous final match and timeout on the same edge: pass wins, `fail` stays 0.
- Duplicate expected markers: consecutive identical markers are unreachable by design; `exp_vals` must alternate.
- `resetb` low mid-operation: asynchronous return to reset values, and no strobe is emitted on the reset edge.

## Configuration
- Macro `CHKMON_STRICT_ORDER_EN`.
- Defined: in ARMED, acceptance of a value equal to any `exp[j]` with j>`chk_idx` sets `err_ooo` and `fail` and goes to FAIL. `timeout` stays 0.
- Not defined: such values are ignored, and `err_ooo` is tied 0.

## Test plan
- Defaults, `exp_vals`={AB61,AB60}. Start, then drive AB60 for 5 cycles and AB61 for 5 cycles -> two `change_stb` pulses; `chk_idx` goes 0→1→2; `pass`=1 at 3 cycles after the first AB61 sample edge; `fail`=0.
- STABLE_CYC=2. Drive AB60 for 2 cycles, 0000, then AB60 again -> no acceptance from the short pulse; AB60 accepted only after 3 sampled edges.
- TIMEOUT_CYC=100, bus held at 0000 -> `fail`=1 and `timeout`=1 in the cycle after edge 99; `cycle_cnt` frozen at 99.
- Final marker accepted on the timeout edge -> `pass`=1, `fail`=0.
- `CHKMON_STRICT_ORDER_EN` defined. Drive AB61 before AB60 -> `err_ooo`=1, `fail`=1, `timeout`=0. Without the macro, the same stimulus followed by AB60 then AB61 -> `pass`=1.
- Pull `resetb` low while `chk_idx`=1 -> all outputs 0 immediately. After release, `start` with AB60 already on the bus -> AB60 re-accepted and `chk_idx`=1 after STABLE_CYC+1 edges.

Source files
------------

// File: rtl/checkbits_seq_monitor.sv
// Checkpoint-sequence monitor for a GPIO marker bus.
// Debounces the bus, matches accepted values in order against NUM_CHK expected
// markers and flags pass / fail / timeout. The optional macro
// CHKMON_STRICT_ORDER_EN turns an early arrival of a later marker into a failure.
module checkbits_seq_monitor #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned NUM_CHK     = 2,
    parameter int unsigned STABLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 250000
) (
    input  logic                             clock,
    input  logic                             resetb,
    input  logic                             start,
    input  logic [WIDTH-1:0]                 checkbits,
    input  logic [NUM_CHK*WIDTH-1:0]         exp_vals,
    output logic                             busy,
    output logic                             pass,
    output logic                             fail,
    output logic                             timeout,
    output logic                             err_ooo,
    output logic [$clog2(NUM_CHK+1)-1:0]     chk_idx,
    output logic                             change_stb,
    output logic [WIDTH-1:0]                 change_val,
    output logic [$clog2(TIMEOUT_CYC+1)-1:0] cycle_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_CHK + 1);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RUN_W = $clog2(STABLE_CYC + 1);

    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYC);
    localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(STABLE_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CHK - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   samp_q, samp_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               acc_vld_q, acc_vld_d;
    logic [WIDTH-1:0]   change_val_q, change_val_d;
    logic               change_stb_q, change_stb_d;
    logic [IDX_W-1:0]   chk_idx_q, chk_idx_d;
    logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;

    logic               arm;
    logic               same;
    logic               accept;
    logic               hit;

`ifdef CHKMON_STRICT_ORDER_EN
    logic               err_ooo_q, err_ooo_d;
    logic               ooo;
`endif

    // State and datapath registers
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state_q      <= ST_IDLE;
            samp_q       <= '0;
            run_q        <= '0;
            acc_vld_q    <= 1'b0;
            change_val_q <= '0;
            change_stb_q <= 1'b0;
            chk_idx_q    <= '0;
            cycle_cnt_q  <= '0;
            pass_q       <= 1'b0;
            fail_q       <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef CHKMON_STRICT_ORDER_EN
            err_ooo_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            samp_q       <= samp_d;
            run_q        <= run_d;
            acc_vld_q    <= acc_vld_d;
            change_val_q <= change_val_d;
            change_stb_q <= change_stb_d;
            chk_idx_q    <= chk_idx_d;
            cycle_cnt_q  <= cycle_cnt_d;
            pass_q       <= pass_d;
            fail_q       <= fail_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
`ifdef CHKMON_STRICT_ORDER_EN
            err_ooo_q    <= err_ooo_d;
`endif
        end
    end

    // Debounce, checkpoint matching and next-state logic
    always_comb begin
        state_d      = state_q;
        samp_d       = checkbits;
        run_d        = run_q;
        acc_vld_d    = acc_vld_q;
        change_val_d = change_val_q;
        change_stb_d = 1'b0;
        chk_idx_d    = chk_idx_q;
        cycle_cnt_d  = cycle_cnt_q;
        pass_d       = pass_q;
        fail_d       = fail_q;
        timeout_d    = timeout_q;
`ifdef CHKMON_STRICT_ORDER_EN
        err_ooo_d    = err_ooo_q;
        ooo          = 1'b0;
`endif
        hit  = 1'b0;
        arm  = start && (state_q != ST_ARMED);
        same = (checkbits == samp_q);

        if (!same) begin
            run_d = '0;
        end else if (run_q != RUN_MAX) begin
            run_d = run_q + RUN_W'(1);
        end

        // The sample that completes a stable run is the accepted value
        accept = !arm && same && (run_q == RUN_PRE)
                 && (!acc_vld_q || (samp_q != change_val_q));

        for (int unsigned i = 0; i < NUM_CHK; i++) begin
            if ((IDX_W'(i) == chk_idx_q) && (samp_q == exp_vals[i*WIDTH +: WIDTH])) begin
                hit = 1'b1;
            end
`ifdef CHKMON_STRICT_ORDER_EN
            if ((IDX_W'(i) > chk_idx_q) && (samp_q == exp_vals[i*WIDTH +: WIDTH])) begin
                ooo = 1'b1;
            end
`endif
        end

        if (accept) begin
            change_val_d = samp_q;
            acc_vld_d    = 1'b1;
            change_stb_d = 1'b1;
        end

        if (arm) begin
            // Re-qualify whatever is on the bus so it can match checkpoint 0
            state_d     = ST_ARMED;
            run_d       = '0;
            acc_vld_d   = 1'b0;
            chk_idx_d   = '0;
            cycle_cnt_d = '0;
            pass_d      = 1'b0;
            fail_d      = 1'b0;
            timeout_d   = 1'b0;
`ifdef CHKMON_STRICT_ORDER_EN
            err_ooo_d   = 1'b0;
`endif
        end else if (state_q == ST_ARMED) begin
            if (accept && hit) begin
                chk_idx_d = chk_idx_q + IDX_W'(1);
                if (chk_idx_q == IDX_LAST) begin
                    pass_d  = 1'b1;
                    state_d = ST_PASS;
                end
            end
`ifdef CHKMON_STRICT_ORDER_EN
            if ((state_d == ST_ARMED) && accept && !hit && ooo) begin
                err_ooo_d = 1'b1;
                fail_d    = 1'b1;
                state_d   = ST_FAIL;
            end
`endif
            // A pass on the timeout edge takes precedence
            if ((state_d == ST_ARMED) && (cycle_cnt_q == CNT_LAST)) begin
                fail_d    = 1'b1;
                timeout_d = 1'b1;
                state_d   = ST_FAIL;
            end
            if (state_d == ST_ARMED) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
        end

        busy_d = (state_d == ST_ARMED);
    end

    assign busy       = busy_q;
    assign pass       = pass_q;
    assign fail       = fail_q;
    assign timeout    = timeout_q;
    assign chk_idx    = chk_idx_q;
    assign change_stb = change_stb_q;
    assign change_val = change_val_q;
    assign cycle_cnt  = cycle_cnt_q;
`ifdef CHKMON_STRICT_ORDER_EN
    assign err_ooo    = err_ooo_q;
`else
    assign err_ooo    = 1'b0;
`endif

endmodule
